// File: rtl/lif_array_if.sv
// Step strobe, per-neuron currents and spike/refractory outputs of lif_array.
// Optional spike-counter signals exist only under LIF_ARRAY_SPIKE_COUNT_EN.
interface lif_array_if #(
  parameter int NUM_NEURONS = 4,
  parameter int WIDTH       = 8
);
  logic                         step_i;
  logic [NUM_NEURONS*WIDTH-1:0] current_i;
  logic [NUM_NEURONS-1:0]       spike_o;
  logic [NUM_NEURONS-1:0]       refrac_o;
`ifdef LIF_ARRAY_SPIKE_COUNT_EN
  logic                         cnt_clr_i;
  logic [NUM_NEURONS*16-1:0]    spike_cnt_o;

  modport master (output step_i, current_i, cnt_clr_i,
                  input  spike_o, refrac_o, spike_cnt_o);
  modport slave  (input  step_i, current_i, cnt_clr_i,
                  output spike_o, refrac_o, spike_cnt_o);
`else
  modport master (output step_i, current_i, input spike_o, refrac_o);
  modport slave  (input step_i, current_i, output spike_o, refrac_o);
`endif
endinterface

// File: rtl/lif_array.sv
// lif_array: NUM_NEURONS adaptive-threshold LIF neurons; LIF_ARRAY_SPIKE_COUNT_EN adds spike counters.
// Latency 1 cycle from a step to spike_o; no backpressure, step_i may be high every cycle.
module lif_array #(
  parameter int NUM_NEURONS = 4,
  parameter int WIDTH       = 8,
  parameter int LEAK_SHIFT  = 1,
  parameter int THRESH_INIT = 128,
  parameter int THRESH_INC  = 5,
  parameter int THRESH_DEC  = 1,
  parameter int THRESH_MIN  = 75,
  parameter int THRESH_MAX  = 250,
  parameter int REFRACT     = 2
) (
  input logic          clk_i,
  input logic          rst_ni,
  lif_array_if.slave   bus
);
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  localparam logic [WIDTH-1:0] TH_INIT_W = WIDTH'(THRESH_INIT);
  localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(THRESH_MIN);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(THRESH_MAX);
  localparam logic [WIDTH-1:0] DEC_W     = WIDTH'(THRESH_DEC);
  localparam logic [WIDTH:0]   INC_X     = (WIDTH+1)'(THRESH_INC);
  localparam logic [WIDTH:0]   MAX_X     = {1'b0, MAX_W};
  localparam logic [RW-1:0]    REFRACT_W = RW'(REFRACT);

  if (!(THRESH_MIN <= THRESH_INIT && THRESH_INIT <= THRESH_MAX &&
        THRESH_MAX < (1 << WIDTH))) begin : g_thresh_check
    $error("lif_array: need THRESH_MIN <= THRESH_INIT <= THRESH_MAX < 2**WIDTH");
  end
  if (LEAK_SHIFT < 1 || LEAK_SHIFT > WIDTH - 1) begin : g_leak_check
    $error("lif_array: LEAK_SHIFT must be within 1..WIDTH-1");
  end

  logic [NUM_NEURONS-1:0] spike_vec;
  logic [NUM_NEURONS-1:0] refrac_vec;

  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_neuron
    logic [WIDTH-1:0] mem_q, th_q;
    logic [RW-1:0]    r_q;
    logic             spike_q, refrac_q;

    logic [WIDTH-1:0] cur, v, th_inc, th_dec, mem_nxt, th_nxt;
    logic [WIDTH:0]   sum, th_up;
    logic [RW-1:0]    r_nxt;
    logic             fire;

    assign cur = bus.current_i[i*WIDTH +: WIDTH];
    // One extra bit catches the carry so the sum can be clamped instead of wrapped.
    assign sum = {1'b0, cur} + {1'b0, mem_q >> LEAK_SHIFT};
    assign v   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

    assign th_up  = {1'b0, th_q} + INC_X;
    assign th_inc = (th_up > MAX_X) ? MAX_W : th_up[WIDTH-1:0];
    assign th_dec = (th_q <= MIN_W)          ? th_q :
                    ((th_q - MIN_W) > DEC_W) ? th_q - DEC_W : MIN_W;

    always_comb begin
      fire    = 1'b0;
      mem_nxt = '0;
      r_nxt   = r_q;
      th_nxt  = th_dec;
      if (r_q != '0) begin
        r_nxt = r_q - RW'(1);
      end else if (v >= th_q) begin
        fire   = 1'b1;
        r_nxt  = REFRACT_W;
        th_nxt = th_inc;
      end else begin
        mem_nxt = v;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        mem_q    <= '0;
        th_q     <= TH_INIT_W;
        r_q      <= '0;
        spike_q  <= 1'b0;
        refrac_q <= 1'b0;
      end else if (bus.step_i) begin
        mem_q    <= mem_nxt;
        th_q     <= th_nxt;
        r_q      <= r_nxt;
        spike_q  <= fire;
        refrac_q <= (r_nxt != '0);
      end else begin
        spike_q  <= 1'b0;
      end
    end

    assign spike_vec[i]  = spike_q;
    assign refrac_vec[i] = refrac_q;

`ifdef LIF_ARRAY_SPIKE_COUNT_EN
    logic [15:0] cnt_q;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk_i) begin
      if (!rst_ni || bus.cnt_clr_i) begin
        cnt_q <= '0;
      end else if (spike_q && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end

    assign bus.spike_cnt_o[i*16 +: 16] = cnt_q;
`endif
  end

  assign bus.spike_o  = spike_vec;
  assign bus.refrac_o = refrac_vec;

endmodule
